// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte valid/ready handshake feeding the UART transmit FIFO.
interface uart_tx_fifo_if;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;

  modport master (
    output DATA,
    output VALID,
    input  READY
  );

  modport slave (
    input  DATA,
    input  VALID,
    output READY
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, bytes queued in a small FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit (11-bit frame).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 400,
  parameter int FIFO_AW      = 2
) (
  input  logic             CLK,
  input  logic             RST,
  uart_tx_fifo_if.slave    bus_if,
  output logic             TX,
  output logic             BUSY,
  output logic [FIFO_AW:0] COUNT
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             ready_q;
  logic             tx_q, tx_d;
  logic             busy_q;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             push, pop;
  logic             empty, full_d, last;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = bus_if.VALID && ready_q;
  assign last  = (cnt_q == CNT_LAST);

  assign wr_ptr_d = wr_ptr_q
    + {{FIFO_AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q
    + {{FIFO_AW{1'b0}}, pop};

  // READY is registered, so it is derived from next-state pointers
  assign full_d =
    (wr_ptr_d[FIFO_AW] != rd_ptr_d[FIFO_AW]) &&
    (wr_ptr_d[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (last) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (last) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (last) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) shift_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^shift_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= !full_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != S_IDLE);
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= bus_if.DATA;
  end

  assign bus_if.READY = ready_q;
  assign TX           = tx_q;
  assign BUSY         = busy_q;
  assign COUNT        = wr_ptr_q - rd_ptr_q;

endmodule
